// File: rtl/if_spike_classifier.sv
// if_spike_classifier
// Output-decoding stage for the IF network. Counts spikes per output neuron
// over a fixed observation window, then walks the counts one neuron per cycle
// to find the most active neuron. The winning index, its count and a tie flag
// are offered to the host through a valid/ready handshake.

module if_spike_classifier #(
    parameter int NUM_OUTPUTS   = 4,
    parameter int CLASS_WIDTH   = 2,
    parameter int COUNT_WIDTH   = 8,
    parameter int WINDOW_CYCLES = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_OUTPUTS-1:0] spike_in,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [CLASS_WIDTH-1:0] class_out,
    output logic [COUNT_WIDTH-1:0] max_count,
    output logic                   tie
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_COMPARE = 2'd2,
        S_HOLD    = 2'd3
    } state_e;

    // Window counter is sized for the largest legal window (65535).
    localparam int                   WIN_WIDTH = 16;
    localparam logic [WIN_WIDTH-1:0] WIN_LOAD  = WIN_WIDTH'(WINDOW_CYCLES);
    localparam logic [WIN_WIDTH-1:0] WIN_LAST  = WIN_WIDTH'(1);

    localparam logic [CLASS_WIDTH-1:0] IDX_FIRST = '0;
    localparam logic [CLASS_WIDTH-1:0] IDX_LAST  = CLASS_WIDTH'(NUM_OUTPUTS - 1);
    localparam logic [CLASS_WIDTH-1:0] IDX_ONE   = CLASS_WIDTH'(1);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;

    logic [COUNT_WIDTH-1:0] cnt_q [NUM_OUTPUTS];
    logic [COUNT_WIDTH-1:0] cnt_d [NUM_OUTPUTS];

    logic [WIN_WIDTH-1:0]   win_q, win_d;
    logic [CLASS_WIDTH-1:0] idx_q, idx_d;

    logic [COUNT_WIDTH-1:0] best_q, best_d;
    logic [CLASS_WIDTH-1:0] best_idx_q, best_idx_d;
    logic                   tie_q, tie_d;

    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;

    // Count value of the neuron currently being examined in COMPARE.
    logic [COUNT_WIDTH-1:0] cur_cnt;

    // Events that drive the FSM.
    logic                   start_accept;
    logic                   window_done;
    logic                   compare_done;
    logic                   handshake;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    // Decode the conditions that move the FSM and the datapath.
    always_comb begin
        start_accept = (state_q == S_IDLE) && start;
        // The last sampling edge is the one that sees the window counter at 1.
        window_done  = (state_q == S_COUNT) && (win_q == WIN_LAST);
        compare_done = (state_q == S_COMPARE) && (idx_q == IDX_LAST);
        handshake    = (state_q == S_HOLD) && valid_q && result_ready;
        cur_cnt      = cnt_q[idx_q];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Hold the current FSM state; reset aborts any window or compare in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // Compute the next FSM state from the current state and decoded events.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path covered,
        // so no latch is inferred for state_d.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_accept) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (window_done) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (compare_done) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Leaving HOLD lands in IDLE; start is only looked at from there,
                // so the handshake edge itself never accepts a new request.
                if (handshake) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    // Derive the flag values for the coming state so the flags are registered.
    always_comb begin
        busy_d  = (state_d == S_COUNT) || (state_d == S_COMPARE);
        valid_d = (state_d == S_HOLD);
    end

    // Register the status flags; both are low out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Spike counters and window counter
    // ------------------------------------------------------------------
    // Clear on an accepted start, count saturating spikes during the window.
    always_comb begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        win_d = win_q;

        if (start_accept) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                cnt_d[i] = '0;
            end
            win_d = WIN_LOAD;
        end else if (state_q == S_COUNT) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                // Saturate instead of wrapping so a busy neuron never looks quiet.
                if (spike_in[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
            win_d = win_q - WIN_LAST;
        end
    end

    // Register the per-neuron counters and the window counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is small and flop-based, and a reset must
            // leave every count at zero, so each entry is reset explicitly.
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                cnt_q[i] <= '0;
            end
            win_q <= '0;
        end else begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            win_q <= win_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequential arg-max scan
    // ------------------------------------------------------------------
    // Examine one neuron per COMPARE edge, tracking best count, index and tie.
    always_comb begin
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        tie_d      = tie_q;

        if (start_accept) begin
            idx_d = IDX_FIRST;
        end else if (state_q == S_COMPARE) begin
            if (idx_q == IDX_FIRST) begin
                // Neuron 0 seeds the scan unconditionally.
                best_d     = cur_cnt;
                best_idx_d = IDX_FIRST;
                tie_d      = 1'b0;
            end else if (cur_cnt > best_q) begin
                best_d     = cur_cnt;
                best_idx_d = idx_q;
                tie_d      = 1'b0;
            end else if (cur_cnt == best_q) begin
                // Equal count: keep the lower index already held, flag the tie.
                tie_d = 1'b1;
            end
            if (!compare_done) begin
                idx_d = idx_q + IDX_ONE;
            end
        end
    end

    // Register the scan index and the result being built; these drive the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            tie_q      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            tie_q      <= tie_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all driven straight from flops
    // ------------------------------------------------------------------
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign class_out    = best_idx_q;
    assign max_count    = best_q;
    assign tie          = tie_q;

endmodule

// File: doc/if_spike_classifier.md
# if_spike_classifier

Output-decoding stage that sits directly downstream of the IF network's output layer. It counts spikes on each output neuron over a fixed observation window, then scans the counts sequentially to pick the most active neuron. It presents the winning class index, its count and a tie flag to the host through a valid/ready handshake.

## Interface

Parameters:
- NUM_OUTPUTS, 4, number of output neurons observed; must equal the network's NUM_OUTPUTS; 1..16
- CLASS_WIDTH, 2, width of class index; 2^CLASS_WIDTH >= NUM_OUTPUTS
- COUNT_WIDTH, 8, width of each per-neuron spike counter
- WINDOW_CYCLES, 100, observation window length in clock cycles; 1..65535

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new classification; accepted only in IDLE
- spike_in  input  NUM_OUTPUTS  spike vector from the network output layer; bit i = neuron i
- busy  output  1  high in COUNT and COMPARE
- result_valid  output  1  high in HOLD
- result_ready  input  1  host accepts result
- class_out  output  CLASS_WIDTH  index of winning neuron
- max_count  output  COUNT_WIDTH  spike count of winning neuron
- tie  output  1  more than one neuron reached max_count

## Operation

- States: IDLE, COUNT, COMPARE, HOLD.
- IDLE: start=1 clears all counters, loads the window counter with WINDOW_CYCLES, and goes to COUNT. spike_in is ignored.
- COUNT: on each edge, counter i increments if spike_in[i]=1. Counters saturate at 2^COUNT_WIDTH-1; there is no wrap. The window counter decrements each edge. After exactly WINDOW_CYCLES sampling edges, go to COMPARE.
- COMPARE: one neuron is examined per edge, index 0 to NUM_OUTPUTS-1.
  - Index 0 seeds best = count[0], best_idx = 0, tie = 0.
  - count[i] > best: replace best and best_idx, clear tie.
  - count[i] == best: set tie, keep the lower index.
  - After index NUM_OUTPUTS-1, go to HOLD.
- HOLD: class_out, max_count and tie are stable. When result_valid && result_ready on an edge, go to IDLE.
- start is ignored outside IDLE. The handshake edge that leaves HOLD does not accept start; start is accepted on the next edge at the earliest.
- All spikes zero: class_out=0, max_count=0, tie=1 if NUM_OUTPUTS>1, else tie=0.
- NUM_OUTPUTS=1: COMPARE lasts one cycle, tie is always 0.
- spike_in is sampled directly; it comes from the same clock domain and needs no synchronizer.

## Timing

- Reset (async assert): state=IDLE, busy=0, result_valid=0, class_out=0, max_count=0, tie=0, all counters 0. Reset mid-window or mid-compare aborts the operation; no result is produced.
- Edge numbering: start is accepted at edge E0.
  - busy=1 from E0 until E(W+N), where W=WINDOW_CYCLES and N=NUM_OUTPUTS.
  - Spikes are sampled at edges E1..EW inclusive. spike_in at E0 and at E(W+1) onward is not counted.
  - COMPARE uses edges E(W+1)..E(W+N).
  - result_valid=1 after E(W+N).
- Latency from start edge to result_valid: W+N cycles.
- result_valid stays high, and outputs hold, for any number of cycles while result_ready=0. It drops on the edge where result_ready=1.
- result_ready while not in HOLD has no effect.
- Outputs are registered; no combinational path from any input to any output.

## Test plan

- Reset with W=10, N=4: assert rst mid-COUNT -> busy=0, result_valid=0, outputs 0 immediately. After release, start -> fresh window with all counters 0.
- W=10, N=4: neuron 2 spikes 7 times, neuron 1 spikes 3 times, others 0. start at E0, result_ready=1 -> result_valid after E14; class_out=2, max_count=7, tie=0. Spike pulses at E0 and E11 on neuron 2 are not counted.
- Tie: neurons 1 and 3 each spike 5 times, W=10 -> class_out=1, max_count=5, tie=1.
- Saturation: COUNT_WIDTH=4, W=40, neuron 0 spikes every cycle -> max_count=15, class_out=0, tie=0.
- No spikes, W=10, N=4 -> class_out=0, max_count=0, tie=1.
- Handshake: hold result_ready=0 for 20 cycles -> result_valid and outputs stable. Pulse start during HOLD -> ignored. result_ready=1 -> IDLE next edge. start on the following edge -> busy=1.
